seq_checker: RTL and testbench
==============================

// Module: seq_checker
// PURPOSE
//  Receive-side checker for the 3-bit sequence generator clocked by the divided clock.
//  Samples the generator state q_in on each rising edge of slow_in and predicts the
//  next state from a parameterised next-state map. It locks after LOCK_COUNT consecutive
//  correct transitions, then flags and counts deviations. It also measures the slow_in
//  period in clk cycles. Runs entirely on clk; slow_in is used only as data.
// PARAMETERS
//  NEXT_MAP    24'o01234567 rotated  3-bit next state for state i = NEXT_MAP[3*i+2:3*i]
//                                    (default 24'o07654321: i -> i+1 mod 8)
//  LOCK_COUNT  4                     consecutive matches needed for lock (1..15)
//  TIMEOUT     16'd60000             clk cycles with no slow_in rise before lock drops
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high
//  slow_in        in   1   divided clock from generator, sampled as data
//  q_in           in   3   generator state, changes after each slow_in rise
//  locked         out  1   high while in LOCKED state
//  err_pulse      out  1   one clk cycle pulse per mismatch while LOCKED
//  stall          out  1   sticky: set on timeout, cleared on next lock
//  expected       out  3   predicted next q_in value
//  err_count      out  8   mismatch count while LOCKED, saturates at 255
//  period_cycles  out  16  clk cycles between the last two slow_in rises, saturating
// BEHAVIOUR
//  Reset: every output is 0, FSM = HUNT, all sync flops are 0, counters are 0.
//  Sync: slow_in and q_in each pass through 2 flops (s1, s2). slow_in also has a third
//   flop s3. rise = s2 & ~s3. On the rise cycle the checker samples q_s = q_in s2 stage.
//   This gives 3 clk cycles of latency from the slow_in edge to the sample.
//  Period: per_cnt increments every clk and saturates at 16'hFFFF. On rise,
//   period_cycles <= per_cnt + 1 (saturating) and per_cnt <= 0. The first rise after
//   reset does not update period_cycles. It stays 0 until the second rise.
//  FSM states HUNT, CHECK, LOCKED. All transitions happen only on rise, except timeout.
//   HUNT:   rise -> expected <= NEXT_MAP[q_s]; match_cnt <= 0; go CHECK.
//   CHECK:  rise and q_s == expected -> match_cnt++; expected <= NEXT_MAP[q_s].
//           If match_cnt+1 == LOCK_COUNT, go LOCKED, locked=1, stall<=0.
//           rise and mismatch -> expected <= NEXT_MAP[q_s]; match_cnt <= 0; stay CHECK.
//           No error is flagged in CHECK.
//   LOCKED: rise and match -> expected <= NEXT_MAP[q_s].
//           rise and mismatch -> err_pulse=1 for that cycle; err_count++ (saturate at
//           255); expected <= NEXT_MAP[q_s]; match_cnt <= 0; go CHECK; locked=0.
//  Timeout: idle counter cleared on rise, otherwise incremented. In CHECK or LOCKED,
//   when idle reaches TIMEOUT: go HUNT, locked=0, stall<=1, err_count unchanged.
//  Simultaneous rise and timeout: rise wins.
//  err_count is cleared only by reset. locked and err_pulse are registered outputs.
//  Reset asserted mid-operation returns everything to reset values immediately.
// TESTING  (bench: LOCK_COUNT=4, TIMEOUT=100, default NEXT_MAP, slow_in period 20 clk)
//  1 Clean count 0..7 repeated -> locked=1 on the 4th checked transition (5th rise),
//    err_count=0, period_cycles=20 from the 2nd rise onward.
//  2 When locked, inject q=5 where 3 is expected -> exactly one err_pulse, err_count=1,
//    locked=0, relock after 4 more good transitions.
//  3 Stop slow_in while locked -> after 100 idle clk: locked=0, stall=1; on restart,
//    relock clears stall.
//  4 Repeated glitches while locked, 300 times -> err_count saturates at 255, no wrap.
//  5 Assert reset mid-lock -> all outputs 0 immediately; first post-reset rise leaves
//    period_cycles=0.
//  6 Wrap 7->0 and a custom NEXT_MAP (Gray sequence) -> lock achieved, no err_pulse.

Source files
------------

// File: rtl/seq_checker.sv
// Locks onto a 3-bit sequence sampled on slow_in rises, then flags and counts deviations and measures the slow_in period.
// Latency: 3 clk from the slow_in edge to the sample, and 1 more clk to the registered outputs; no backpressure, the checker always accepts input.
module seq_checker #(
    parameter logic [23:0] NEXT_MAP   = 24'o07654321,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TIMEOUT    = 16'd60000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        slow_in,
    input  logic [2:0]  q_in,
    output logic        locked,
    output logic        err_pulse,
    output logic        stall,
    output logic [2:0]  expected,
    output logic [7:0]  err_count,
    output logic [15:0] period_cycles
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]  LOCK_CNT    = 4'(LOCK_COUNT);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    function automatic logic [2:0] next_of(input logic [2:0] s);
        logic [23:0] sh;
        sh = NEXT_MAP >> ({2'b00, s} * 5'd3);
        return sh[2:0];
    endfunction

    state_t      state_q, state_d;
    logic        slow_s1_q, slow_s1_d;
    logic        slow_s2_q, slow_s2_d;
    logic        slow_s3_q, slow_s3_d;
    logic [2:0]  q_s1_q, q_s1_d;
    logic [2:0]  q_s2_q, q_s2_d;
    logic [15:0] per_cnt_q, per_cnt_d;
    logic [15:0] idle_q, idle_d;
    logic        seen_rise_q, seen_rise_d;
    logic [3:0]  match_cnt_q, match_cnt_d;
    logic        locked_q, locked_d;
    logic        err_pulse_q, err_pulse_d;
    logic        stall_q, stall_d;
    logic [2:0]  expected_q, expected_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [15:0] period_q, period_d;

    logic       rise;
    logic       q_match;
    logic [2:0] q_next;
    logic       timed_out;

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        stall_d     = stall_q;
        expected_d  = expected_q;
        err_count_d = err_count_q;
        period_d    = period_q;
        seen_rise_d = seen_rise_q;
        err_pulse_d = 1'b0;

        slow_s1_d = slow_in;
        slow_s2_d = slow_s1_q;
        slow_s3_d = slow_s2_q;
        q_s1_d    = q_in;
        q_s2_d    = q_s1_q;

        rise      = slow_s2_q & ~slow_s3_q;
        q_match   = (q_s2_q == expected_q);
        q_next    = next_of(q_s2_q);
        timed_out = (idle_q >= TIMEOUT_CNT);

        per_cnt_d = (per_cnt_q == 16'hFFFF) ? per_cnt_q : per_cnt_q + 16'd1;
        idle_d    = (idle_q == 16'hFFFF) ? idle_q : idle_q + 16'd1;

        if (rise) begin
            per_cnt_d   = 16'd0;
            idle_d      = 16'd0;
            seen_rise_d = 1'b1;
            // The first rise only opens the measurement window.
            if (seen_rise_q) begin
                period_d = (per_cnt_q == 16'hFFFF) ? per_cnt_q : per_cnt_q + 16'd1;
            end
        end

        case (state_q)
            HUNT: begin
                if (rise) begin
                    expected_d  = q_next;
                    match_cnt_d = 4'd0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (rise) begin
                    expected_d = q_next;
                    if (q_match) begin
                        match_cnt_d = match_cnt_q + 4'd1;
                        if (match_cnt_q + 4'd1 == LOCK_CNT) begin
                            state_d = LOCKED;
                            stall_d = 1'b0;
                        end
                    end else begin
                        match_cnt_d = 4'd0;
                    end
                end else if (timed_out) begin
                    state_d = HUNT;
                    stall_d = 1'b1;
                end
            end
            LOCKED: begin
                if (rise) begin
                    expected_d = q_next;
                    if (!q_match) begin
                        err_pulse_d = 1'b1;
                        err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
                        match_cnt_d = 4'd0;
                        state_d     = CHECK;
                    end
                end else if (timed_out) begin
                    state_d = HUNT;
                    stall_d = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= HUNT;
            slow_s1_q   <= 1'b0;
            slow_s2_q   <= 1'b0;
            slow_s3_q   <= 1'b0;
            q_s1_q      <= 3'd0;
            q_s2_q      <= 3'd0;
            per_cnt_q   <= 16'd0;
            idle_q      <= 16'd0;
            seen_rise_q <= 1'b0;
            match_cnt_q <= 4'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            stall_q     <= 1'b0;
            expected_q  <= 3'd0;
            err_count_q <= 8'd0;
            period_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            slow_s1_q   <= slow_s1_d;
            slow_s2_q   <= slow_s2_d;
            slow_s3_q   <= slow_s3_d;
            q_s1_q      <= q_s1_d;
            q_s2_q      <= q_s2_d;
            per_cnt_q   <= per_cnt_d;
            idle_q      <= idle_d;
            seen_rise_q <= seen_rise_d;
            match_cnt_q <= match_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            stall_q     <= stall_d;
            expected_q  <= expected_d;
            err_count_q <= err_count_d;
            period_q    <= period_d;
        end
    end

    assign locked        = locked_q;
    assign err_pulse     = err_pulse_q;
    assign stall         = stall_q;
    assign expected      = expected_q;
    assign err_count     = err_count_q;
    assign period_cycles = period_q;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: counting lock, glitch recovery, timeout, reset, saturation, Gray map.
module tb_seq_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        slow_in = 1'b0;
    logic [2:0]  q_in = 3'd0;

    logic        locked, err_pulse, stall;
    logic [2:0]  expected;
    logic [7:0]  err_count;
    logic [15:0] period_cycles;

    logic        locked_g, err_pulse_g, stall_g;
    logic [2:0]  expected_g;
    logic [7:0]  err_count_g;
    logic [15:0] period_cycles_g;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    int pulses_g = 0;

    always #5 clk = ~clk;

    seq_checker #(.LOCK_COUNT(4), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .slow_in(slow_in), .q_in(q_in),
        .locked(locked), .err_pulse(err_pulse), .stall(stall),
        .expected(expected), .err_count(err_count), .period_cycles(period_cycles)
    );

    // Gray order 0,1,3,2,6,7,5,4.
    seq_checker #(.NEXT_MAP(24'o57402631), .LOCK_COUNT(4), .TIMEOUT(100)) dut_gray (
        .clk(clk), .reset(reset), .slow_in(slow_in), .q_in(q_in),
        .locked(locked_g), .err_pulse(err_pulse_g), .stall(stall_g),
        .expected(expected_g), .err_count(err_count_g), .period_cycles(period_cycles_g)
    );

    always @(negedge clk) begin
        if (err_pulse)   pulses   <= pulses + 1;
        if (err_pulse_g) pulses_g <= pulses_g + 1;
    end

    typedef struct {
        logic [2:0] q;
        int         lck;
        int         exp_q;
        int         errs;
        int         per;
        int         npulse;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One slow_in period of 2*half clk with q_in presented at the rising edge.
    task automatic feed(input logic [2:0] q, input int half);
        @(posedge clk);
        #1;
        q_in    = q;
        slow_in = 1'b1;
        repeat (half) @(posedge clk);
        #1;
        slow_in = 1'b0;
        repeat (half - 1) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int base;
        logic [2:0] cur;
        logic [2:0] gray_seq[11];

        vecs[0]  = '{3'd0, 0, 1, 0, 0,  0};
        vecs[1]  = '{3'd1, 0, 2, 0, 20, 0};
        vecs[2]  = '{3'd2, 0, 3, 0, 20, 0};
        vecs[3]  = '{3'd3, 0, 4, 0, 20, 0};
        vecs[4]  = '{3'd4, 1, 5, 0, 20, 0};
        vecs[5]  = '{3'd5, 1, 6, 0, 20, 0};
        vecs[6]  = '{3'd6, 1, 7, 0, 20, 0};
        vecs[7]  = '{3'd7, 1, 0, 0, 20, 0};
        vecs[8]  = '{3'd0, 1, 1, 0, 20, 0};
        vecs[9]  = '{3'd1, 1, 2, 0, 20, 0};
        vecs[10] = '{3'd2, 1, 3, 0, 20, 0};
        vecs[11] = '{3'd5, 0, 6, 1, 20, 1};
        vecs[12] = '{3'd6, 0, 7, 1, 20, 1};
        vecs[13] = '{3'd7, 0, 0, 1, 20, 1};
        vecs[14] = '{3'd0, 0, 1, 1, 20, 1};
        vecs[15] = '{3'd1, 1, 2, 1, 20, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_locked", locked, 0);
        check("reset_err_pulse", err_pulse, 0);
        check("reset_stall", stall, 0);
        check("reset_expected", expected, 0);
        check("reset_err_count", err_count, 0);
        check("reset_period", period_cycles, 0);
        reset = 1'b0;
        base = pulses;

        // Clean counting, wrap, glitch and relock.
        for (int i = 0; i < 16; i++) begin
            feed(vecs[i].q, 10);
            check($sformatf("vec%0d_locked", i), locked, vecs[i].lck);
            check($sformatf("vec%0d_expected", i), expected, vecs[i].exp_q);
            check($sformatf("vec%0d_err_count", i), err_count, vecs[i].errs);
            check($sformatf("vec%0d_period", i), period_cycles, vecs[i].per);
            check($sformatf("vec%0d_pulses", i), pulses - base, vecs[i].npulse);
            check($sformatf("vec%0d_stall", i), stall, 0);
        end

        // slow_in stops while locked.
        repeat (70) @(negedge clk);
        check("idle70_locked", locked, 1);
        check("idle70_stall", stall, 0);
        repeat (20) @(negedge clk);
        check("timeout_locked", locked, 0);
        check("timeout_stall", stall, 1);
        check("timeout_err_count", err_count, 1);
        feed(3'd2, 10);
        feed(3'd3, 10);
        check("restart_period", period_cycles, 20);
        feed(3'd4, 10);
        feed(3'd5, 10);
        check("restart3_locked", locked, 0);
        check("restart3_stall", stall, 1);
        feed(3'd6, 10);
        check("relock_locked", locked, 1);
        check("relock_stall", stall, 0);
        check("relock_expected", expected, 7);

        // Reset while locked clears everything without waiting for a clock.
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midreset_locked", locked, 0);
        check("midreset_expected", expected, 0);
        check("midreset_err_count", err_count, 0);
        check("midreset_period", period_cycles, 0);
        check("midreset_stall", stall, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        feed(3'd0, 10);
        check("post_reset_period", period_cycles, 0);
        check("post_reset_expected", expected, 1);
        feed(3'd1, 10);
        check("post_reset_period2", period_cycles, 20);

        // Saturation of err_count with a shorter period.
        feed(3'd2, 4);
        feed(3'd3, 4);
        feed(3'd4, 4);
        check("sat_prelock", locked, 1);
        check("sat_period8", period_cycles, 8);
        base = pulses;
        cur = 3'd5;
        for (int i = 0; i < 300; i++) begin
            feed(cur + 3'd2, 4);
            if (i == 0)   check("sat_first_err", err_count, 1);
            if (i == 254) check("sat_255", err_count, 255);
            for (int k = 3; k <= 6; k++) feed(cur + 3'(k), 4);
            cur = cur + 3'd7;
        end
        check("sat_err_count", err_count, 255);
        check("sat_pulses", pulses - base, 300);
        check("sat_locked", locked, 1);

        // Gray map on the second instance; the counting map never locks on it.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        gray_seq = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0, 3'd1, 3'd3};
        base = pulses_g;
        for (int i = 0; i < 11; i++) begin
            feed(gray_seq[i], 10);
            if (i == 3) check("gray_prelock", locked_g, 0);
            if (i == 4) check("gray_lock", locked_g, 1);
        end
        check("gray_locked_end", locked_g, 1);
        check("gray_expected", expected_g, 2);
        check("gray_err_count", err_count_g, 0);
        check("gray_pulses", pulses_g - base, 0);
        check("gray_period", period_cycles_g, 20);
        check("count_map_on_gray", locked, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
